// File: rtl/dispatch_queue_if.sv
// Shared decode/issue types and the decoder <-> dispatch queue <-> issue bundle.
`ifndef DataWidth
`define DataWidth 32
`endif

package dispatch_queue_pkg;
  typedef logic [4:0] RegFile_t;
  typedef logic [3:0] OpCommand_t;

  typedef enum logic [2:0] {
    UNIT_NOP    = 3'd0,
    UNIT_ALU    = 3'd1,
    UNIT_LSU    = 3'd2,
    UNIT_BRANCH = 3'd3,
    UNIT_CSR    = 3'd4,
    UNIT_MUL    = 3'd5
  } ExeUnit_t;

  typedef enum logic [1:0] {
    IMM_NO_SHIFT = 2'd0,
    IMM_SHIFT1   = 2'd1,
    IMM_SHIFT12  = 2'd2
  } ImmShift_t;

  typedef enum logic [1:0] {
    IMM_SIZE12   = 2'd0,
    IMM_SIZE20   = 2'd1,
    IMM_SIZE5_12 = 2'd2
  } ImmSize_t;

  typedef struct packed {
    logic        sign;
    ImmShift_t   shift;
    ImmSize_t    size;
    logic [19:0] data;
  } ImmData_t;
endpackage

interface dispatch_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATA  = `DataWidth
);
  import dispatch_queue_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              dec_e_;
  RegFile_t          rs1;
  RegFile_t          rs2;
  RegFile_t          rd;
  logic              invalid;
  ImmData_t          imm_data;
  ExeUnit_t          unit;
  OpCommand_t        command;
  logic              is_full;

  logic              iss_e_;
  logic              iss_ready;
  RegFile_t          iss_rs1;
  RegFile_t          iss_rs2;
  RegFile_t          iss_rd;
  logic              iss_invalid;
  logic [DATA-1:0]   iss_imm;
  logic [11:0]       iss_csr_addr;
  ExeUnit_t          iss_unit;
  OpCommand_t        iss_command;
  logic [CW-1:0]     count;

  modport master (
    output flush, dec_e_, rs1, rs2, rd, invalid, imm_data, unit, command, iss_ready,
    input  is_full, iss_e_, iss_rs1, iss_rs2, iss_rd, iss_invalid, iss_imm,
           iss_csr_addr, iss_unit, iss_command, count
  );

  modport slave (
    input  flush, dec_e_, rs1, rs2, rd, invalid, imm_data, unit, command, iss_ready,
    output is_full, iss_e_, iss_rs1, iss_rs2, iss_rd, iss_invalid, iss_imm,
           iss_csr_addr, iss_unit, iss_command, count
  );
endinterface

// File: rtl/dispatch_queue.sv
// Decode-to-issue FIFO: buffers decoded ops, expands immediates on write,
// presents the oldest op to issue with an active-low valid / ready handshake.
`ifndef DataWidth
`define DataWidth 32
`endif

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DATA  = `DataWidth
) (
  input  logic           clk,
  input  logic           reset_,
  dispatch_queue_if.slave q
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    RegFile_t        rs1;
    RegFile_t        rs2;
    RegFile_t        rd;
    logic            invalid;
    logic [DATA-1:0] imm;
    logic [11:0]     csr;
    ExeUnit_t        unit;
    OpCommand_t      command;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [DATA-1:0] ext;
  logic [DATA-1:0] exp_imm;
  logic [11:0]     exp_csr;
  entry_t          wr_entry;
  entry_t          head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = !q.dec_e_ && !full;
  assign pop   = !empty && q.iss_ready;

  // Extension first, shift second; CSR-immediate form ignores sign and shift.
  always_comb begin
    ext     = '0;
    exp_imm = '0;
    exp_csr = '0;
    case (q.imm_data.size)
      IMM_SIZE12:
        ext = q.imm_data.sign ? DATA'($signed(q.imm_data.data[11:0]))
                              : DATA'(q.imm_data.data[11:0]);
      IMM_SIZE20:
        ext = q.imm_data.sign ? DATA'($signed(q.imm_data.data[19:0]))
                              : DATA'(q.imm_data.data[19:0]);
      IMM_SIZE5_12: begin
        ext     = DATA'(q.imm_data.data[16:12]);
        exp_csr = q.imm_data.data[11:0];
      end
      default: ext = '0;
    endcase

    if (q.imm_data.size == IMM_SIZE5_12) begin
      exp_imm = ext;
    end else begin
      case (q.imm_data.shift)
        IMM_SHIFT1:  exp_imm = ext << 1;
        IMM_SHIFT12: exp_imm = ext << 12;
        default:     exp_imm = ext;
      endcase
    end
  end

  always_comb begin
    wr_entry.rs1     = q.rs1;
    wr_entry.rs2     = q.rs2;
    wr_entry.rd      = q.rd;
    wr_entry.invalid = q.invalid;
    wr_entry.imm     = exp_imm;
    wr_entry.csr     = exp_csr;
    wr_entry.unit    = q.unit;
    wr_entry.command = q.command;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every output is gated while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !q.flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign q.is_full      = full;
  assign q.iss_e_       = empty;
  assign q.count        = count_q;
  assign q.iss_rs1      = empty ? '0 : head.rs1;
  assign q.iss_rs2      = empty ? '0 : head.rs2;
  assign q.iss_rd       = empty ? '0 : head.rd;
  assign q.iss_invalid  = empty ? 1'b0 : head.invalid;
  assign q.iss_imm      = empty ? '0 : head.imm;
  assign q.iss_csr_addr = empty ? '0 : head.csr;
  assign q.iss_unit     = empty ? UNIT_NOP : head.unit;
  assign q.iss_command  = empty ? '0 : head.command;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: immediate-expansion vector table plus
// hand-written full, streaming, flush and asynchronous-reset sequences.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic clk;
  logic reset_;
  int   checks;
  int   errors;

  dispatch_queue_if #(.DEPTH(4), .DATA(32)) bus ();

  dispatch_queue #(.DEPTH(4), .DATA(32)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .q      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        sign;
    ImmShift_t   shift;
    ImmSize_t    size;
    logic [19:0] data;
    ExeUnit_t    unit;
    logic        invalid;
    logic [31:0] exp_imm;
    logic [11:0] exp_csr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.dec_e_    = 1'b1;
    bus.iss_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic drive_tag(input int t);
    bus.rs1      = RegFile_t'(t);
    bus.rs2      = RegFile_t'(t + 1);
    bus.rd       = RegFile_t'(t + 2);
    bus.invalid  = 1'b0;
    bus.imm_data = '{sign: 1'b0, shift: IMM_NO_SHIFT, size: IMM_SIZE12, data: 20'(t)};
    bus.unit     = UNIT_ALU;
    bus.command  = OpCommand_t'(t);
  endtask

  task automatic chk_head(input string nm, input int t);
    chk({nm, "_rd"},  32'(bus.iss_rd), 32'(RegFile_t'(t + 2)));
    chk({nm, "_imm"}, bus.iss_imm, 32'(t));
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_iss_e_"}, 32'(bus.iss_e_), 32'd1);
    chk({nm, "_count"},  32'(bus.count), 32'd0);
    chk({nm, "_imm"},    bus.iss_imm, 32'd0);
    chk({nm, "_csr"},    32'(bus.iss_csr_addr), 32'd0);
    chk({nm, "_unit"},   32'(bus.iss_unit), 32'(UNIT_NOP));
    chk({nm, "_rd"},     32'(bus.iss_rd), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, IMM_NO_SHIFT, IMM_SIZE12,   20'h00FFC, UNIT_LSU,    1'b0, 32'hFFFF_FFFC, 12'h000};
    vecs[1] = '{1'b0, IMM_SHIFT12,  IMM_SIZE20,   20'h12345, UNIT_ALU,    1'b0, 32'h1234_5000, 12'h000};
    vecs[2] = '{1'b0, IMM_SHIFT1,   IMM_SIZE20,   20'h80001, UNIT_BRANCH, 1'b0, 32'h0010_0002, 12'h000};
    vecs[3] = '{1'b1, IMM_SHIFT12,  IMM_SIZE5_12, 20'h1F300, UNIT_CSR,    1'b0, 32'h0000_001F, 12'h300};
    vecs[4] = '{1'b1, IMM_SHIFT1,   IMM_SIZE12,   20'h00800, UNIT_BRANCH, 1'b0, 32'hFFFF_F000, 12'h000};
    vecs[5] = '{1'b1, IMM_NO_SHIFT, IMM_SIZE20,   20'h80000, UNIT_ALU,    1'b0, 32'hFFF8_0000, 12'h000};
    vecs[6] = '{1'b0, IMM_NO_SHIFT, IMM_SIZE12,   20'hABFFC, UNIT_ALU,    1'b0, 32'h0000_0FFC, 12'h000};
    vecs[7] = '{1'b0, IMM_NO_SHIFT, IMM_SIZE12,   20'h00000, UNIT_NOP,    1'b1, 32'h0000_0000, 12'h000};
    vecs[8] = '{1'b1, IMM_SHIFT12,  IMM_SIZE12,   20'h00800, UNIT_ALU,    1'b0, 32'hFF80_0000, 12'h000};

    reset_ = 1'b0;
    idle();
    drive_tag(0);
    #2;
    chk("rst_is_full", 32'(bus.is_full), 32'd0);
    chk_empty("rst");
    @(negedge clk);
    reset_ = 1'b1;

    // Immediate expansion: push into empty queue, check head, pop, check gated.
    for (int unsigned i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.rs1      = RegFile_t'(i + 1);
      bus.rs2      = RegFile_t'(i + 2);
      bus.rd       = RegFile_t'(i + 3);
      bus.invalid  = vecs[i].invalid;
      bus.imm_data = '{sign: vecs[i].sign, shift: vecs[i].shift, size: vecs[i].size, data: vecs[i].data};
      bus.unit     = vecs[i].unit;
      bus.command  = OpCommand_t'(i);
      bus.dec_e_   = 1'b0;
      @(negedge clk);
      bus.dec_e_ = 1'b1;
      chk($sformatf("v%0d_iss_e_", i),   32'(bus.iss_e_), 32'd0);
      chk($sformatf("v%0d_count", i),    32'(bus.count), 32'd1);
      chk($sformatf("v%0d_imm", i),      bus.iss_imm, vecs[i].exp_imm);
      chk($sformatf("v%0d_csr", i),      32'(bus.iss_csr_addr), 32'(vecs[i].exp_csr));
      chk($sformatf("v%0d_unit", i),     32'(bus.iss_unit), 32'(vecs[i].unit));
      chk($sformatf("v%0d_invalid", i),  32'(bus.iss_invalid), 32'(vecs[i].invalid));
      chk($sformatf("v%0d_cmd", i),      32'(bus.iss_command), 32'(OpCommand_t'(i)));
      chk($sformatf("v%0d_rs1", i),      32'(bus.iss_rs1), 32'(RegFile_t'(i + 1)));
      bus.iss_ready = 1'b1;
      @(negedge clk);
      bus.iss_ready = 1'b0;
      chk_empty($sformatf("v%0d_pop", i));
    end

    // Fill to full, hold a fifth op, one pop frees a slot for it next cycle.
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      drive_tag(t);
      bus.dec_e_ = 1'b0;
    end
    @(negedge clk);
    drive_tag(5);
    chk("full_is_full", 32'(bus.is_full), 32'd1);
    chk("full_count", 32'(bus.count), 32'd4);
    @(negedge clk);
    chk("hold_count", 32'(bus.count), 32'd4);
    chk_head("hold_head", 1);
    bus.iss_ready = 1'b1;
    @(negedge clk);
    bus.iss_ready = 1'b0;
    chk("popfull_count", 32'(bus.count), 32'd3);
    chk("popfull_is_full", 32'(bus.is_full), 32'd0);
    chk_head("popfull_head", 2);
    @(negedge clk);
    bus.dec_e_ = 1'b1;
    chk("accept5_count", 32'(bus.count), 32'd4);
    bus.iss_ready = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      chk_head($sformatf("order%0d", t), t);
      @(negedge clk);
    end
    bus.iss_ready = 1'b0;
    chk_empty("drain");

    // Streaming at count=2: pointers wrap several times, order must hold.
    @(negedge clk);
    drive_tag(10);
    bus.dec_e_ = 1'b0;
    @(negedge clk);
    drive_tag(11);
    @(negedge clk);
    chk("stream_start_count", 32'(bus.count), 32'd2);
    drive_tag(12);
    bus.iss_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_count", k), 32'(bus.count), 32'd2);
      chk_head($sformatf("stream%0d", k), 11 + k);
      drive_tag(13 + k);
    end
    bus.dec_e_ = 1'b1;
    @(negedge clk);
    chk("stream_tail_count", 32'(bus.count), 32'd1);
    chk_head("stream_tail", 21);
    @(negedge clk);
    bus.iss_ready = 1'b0;
    chk_empty("stream_end");

    // Flush with a simultaneous push at 3 entries: push is dropped.
    for (int t = 30; t <= 32; t++) begin
      @(negedge clk);
      drive_tag(t);
      bus.dec_e_ = 1'b0;
    end
    @(negedge clk);
    chk("preflush_count", 32'(bus.count), 32'd3);
    drive_tag(33);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush  = 1'b0;
    bus.dec_e_ = 1'b1;
    chk_empty("flush");
    drive_tag(34);
    bus.dec_e_ = 1'b0;
    @(negedge clk);
    bus.dec_e_ = 1'b1;
    chk("postflush_count", 32'(bus.count), 32'd1);
    chk_head("postflush", 34);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;

    // Flush while full: is_full drops after the flush edge.
    for (int t = 50; t <= 53; t++) begin
      @(negedge clk);
      drive_tag(t);
      bus.dec_e_ = 1'b0;
    end
    @(negedge clk);
    bus.dec_e_ = 1'b1;
    chk("preflush_full", 32'(bus.is_full), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flushfull_is_full", 32'(bus.is_full), 32'd0);
    chk("flushfull_count", 32'(bus.count), 32'd0);

    // Asynchronous reset between clock edges with entries held.
    for (int t = 40; t <= 41; t++) begin
      @(negedge clk);
      drive_tag(t);
      bus.dec_e_ = 1'b0;
    end
    @(negedge clk);
    bus.dec_e_ = 1'b1;
    chk("prereset_count", 32'(bus.count), 32'd2);
    #2;
    reset_ = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst_is_full", 32'(bus.is_full), 32'd0);
    #1;
    reset_ = 1'b1;
    @(negedge clk);
    chk("postreset_iss_e_", 32'(bus.iss_e_), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Consumer end of the decode-stage interface: accepts registered decoded ops from the decoder and drives the `is_full` back-pressure the decoder stalls on.
- Buffers ops in a DEPTH-entry FIFO.
- Expands the compressed `ImmData_t` immediate into a full DATA-wide operand (plus a CSR address) at write time.
- Presents the oldest entry to the issue/rename stage with a valid/ready handshake.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- DATA, `DataWidth, width of the expanded immediate.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (mispredict/exception).
- dec_e_  in  1  decoded op valid, active-low.
- rs1 / rs2 / rd  in  RegFile_t  source and destination operands.
- invalid  in  1  decoder flagged an illegal instruction.
- imm_data  in  ImmData_t  compressed immediate: sign, shift, size, data.
- unit  in  ExeUnit_t  target execution unit.
- command  in  OpCommand_t  unit command.
- is_full  out  1  queue full; decoder holds its output while asserted.
- iss_e_  out  1  head entry valid, active-low.
- iss_ready  in  1  issue stage consumes the head this cycle.
- iss_rs1 / iss_rs2 / iss_rd  out  RegFile_t  head operands.
- iss_invalid  out  1  head invalid flag.
- iss_imm  out  DATA  expanded immediate.
- iss_csr_addr  out  12  CSR address (IMM_SIZE5_12 ops only, else 0).
- iss_unit  out  ExeUnit_t  head unit.
- iss_command  out  OpCommand_t  head command.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:

Reset:
- reset_ low: count=0 and read/write pointers=0.
- is_full=0, iss_e_=1.
- All iss_* data outputs =0; iss_unit=UNIT_NOP.

Handshake:
- push = !dec_e_ && !is_full.
- pop = !iss_e_ && iss_ready.
- is_full = (count==DEPTH), decoded from the registered count only.
- A push in a full cycle is ignored even if a pop occurs in the same cycle. The decoder keeps holding the op and it is accepted the next cycle.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged, both pointers advance.

Timing and ordering:
- Latency: an op pushed at edge N is visible at the head (iss_e_=0) from edge N onward, if the queue was empty.
- FIFO order is strict.
- Pointers wrap modulo DEPTH.

Output gating:
- iss_e_ = (count==0).
- While empty, all iss_* data outputs are forced to 0 and iss_unit to UNIT_NOP.
- While non-empty, outputs show the stored head entry; they are stable until popped.

Flush:
- Takes priority over push and pop in the same cycle.
- Next edge: count=0, pointers=0, no write occurs.
- is_full drops the cycle after the flush edge.

Invalid ops:
- Stored and issued unchanged: iss_invalid=1, unit/command as given (decoder supplies UNIT_NOP).
- Not dropped; the commit stage raises the exception.

Immediate expansion (combinational on write path, stored expanded):
- Field by size:
  - IMM_SIZE12: f=data[11:0], width 12.
  - IMM_SIZE20: f=data[19:0], width 20.
  - IMM_SIZE5_12: iss_imm = zero-extended data[16:12] (zimm, shift ignored); iss_csr_addr = data[11:0].
- Extension: sign=1 sign-extends f from its MSB to DATA; sign=0 zero-extends.
- Shift, applied after extension, truncated to DATA: IMM_NO_SHIFT <<0, IMM_SHIFT1 <<1, IMM_SHIFT12 <<12.
- iss_csr_addr=0 for every size other than IMM_SIZE5_12.
- Extension and shift are applied exactly as encoded; the dispatch queue does not reinterpret the sign bit per opcode.

Reset mid-operation:
- Asserting reset_ with entries held discards them immediately (asynchronous).
- Outputs return to reset values without waiting for clk.

Test Plan:
- Reset, then push one LOAD with imm_data{sign=1,NO_SHIFT,SIZE12,data=0xFFC} -> next cycle iss_e_=0, iss_imm=0xFFFF_FFFC (DATA=32), count=1. Pop -> iss_e_=1, outputs zeroed.
- Push 4 ops with iss_ready=0 -> is_full=1 after 4th edge. 5th op held on dec_e_=0 is not accepted. Assert iss_ready for one cycle -> 5th op accepted the following cycle; pops return ops 1..5 in order.
- Push and pop simultaneously every cycle for 10 cycles, starting from count=2 -> count stays 2, pointers wrap, order preserved.
- LUI imm{sign=0,SHIFT12,SIZE20,data=0x12345} -> iss_imm=0x1234_5000. JAL imm{sign=0,SHIFT1,SIZE20,data=0x80001} -> iss_imm=0x0010_0002.
- CSRRWI imm{SIZE5_12,data={5'h1F,12'h300}} -> iss_imm=0x1F, iss_csr_addr=0x300. An invalid op -> iss_invalid=1, iss_unit=UNIT_NOP.
- Queue at 3 entries, flush asserted with a simultaneous push -> count=0 and iss_e_=1 next cycle, pushed op dropped. Async reset_ pulse mid-cycle with entries held -> iss_e_=1 immediately.
